// File: rtl/sdram_bist_pkg.sv
// Shared types and LFSR definition for the SDRAM Wishbone BIST.
package sdram_bist_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      WRITE  = 3'd1,
      WDRAIN = 3'd2,
      READ   = 3'd3,
      RDRAIN = 3'd4,
      DONE   = 3'd5
   } state_t;

   localparam int LFSR_TAP_A = 31;
   localparam int LFSR_TAP_B = 21;
   localparam int LFSR_TAP_C = 1;
   localparam int LFSR_TAP_D = 0;

   function automatic logic [31:0] lfsr_next(input logic [31:0] d);
      return {d[30:0], d[LFSR_TAP_A] ^ d[LFSR_TAP_B] ^ d[LFSR_TAP_C] ^ d[LFSR_TAP_D]};
   endfunction

endpackage

// File: rtl/sdram_bist_if.sv
// Pipelined Wishbone bus between the BIST master and the memory slave.
interface sdram_bist_if;
   logic [31:0] addr_o;
   logic [31:0] data_o;
   logic [31:0] data_i;
   logic [3:0]  sel_o;
   logic        stb_o;
   logic        cyc_o;
   logic        we_o;
   logic        stall_i;
   logic        ack_i;

   modport master (
      output addr_o, data_o, sel_o, stb_o, cyc_o, we_o,
      input  data_i, stall_i, ack_i
   );

   modport slave (
      input  addr_o, data_o, sel_o, stb_o, cyc_o, we_o,
      output data_i, stall_i, ack_i
   );
endinterface

// File: rtl/sdram_bist_lfsr.sv
// 32-bit pattern LFSR: synchronous load of SEED takes priority over advance.
module sdram_bist_lfsr
   import sdram_bist_pkg::*;
#(
   parameter logic [31:0] SEED = 32'h1234_5678
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic        advance,
   output logic [31:0] value
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)          value <= SEED;
      else if (load)    value <= SEED;
      else if (advance) value <= lfsr_next(value);
   end

endmodule

// File: rtl/sdram_bist.sv
// Write-then-read-back Wishbone memory BIST with bounded outstanding requests.
// Optional cycle counter is enabled by defining SDRAM_BIST_PERF_EN.
module sdram_bist
   import sdram_bist_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
   parameter int          WORDS           = 1024,
   parameter int          MAX_OUTSTANDING = 4,
   parameter logic [31:0] SEED            = 32'h1234_5678
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                start_i,
   sdram_bist_if.master        bus,
   output logic                busy_o,
   output logic                done_o,
   output logic                pass_o,
   output logic [15:0]         err_count_o,
   output logic [31:0]         err_addr_o,
   output logic [31:0]         cycles_o
);

   localparam logic [20:0] LAST_REQ = 21'(WORDS - 1);
   localparam logic [3:0]  MAX_OUT  = 4'(MAX_OUTSTANDING);

   state_t      state, state_next;
   logic [20:0] req_count;
   logic [3:0]  outstanding;
   logic [31:0] exp_addr;
   logic [31:0] gen_value;
   logic [31:0] chk_value;
   logic [31:0] req_addr;
   logic        start_run;
   logic        accept;
   logic        ack_valid;
   logic        read_ack;
   logic        read_start;
   logic        mismatch;
   logic        last_req;

   assign req_addr   = BASE_ADDR + {9'd0, req_count, 2'b00};
   assign start_run  = start_i && (state == IDLE || state == DONE);
   assign accept     = bus.stb_o && !bus.stall_i;
   assign ack_valid  = bus.ack_i && (outstanding != 4'd0);
   assign read_ack   = ack_valid && (state == READ || state == RDRAIN);
   assign read_start = (state == WDRAIN) && (outstanding == 4'd0);
   assign mismatch   = read_ack && (bus.data_i != chk_value);
   assign last_req   = (req_count == LAST_REQ);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state <= IDLE;
      else       state <= state_next;
   end

   // Bus outputs decode straight from state so reset drops cyc/stb at once.
   always_comb begin
      state_next  = state;
      busy_o      = 1'b0;
      done_o      = 1'b0;
      bus.cyc_o   = 1'b0;
      bus.stb_o   = 1'b0;
      bus.we_o    = 1'b0;
      bus.addr_o  = 32'd0;
      bus.data_o  = 32'd0;
      bus.sel_o   = 4'hF;
      case (state)
         IDLE: begin
            if (start_i) state_next = WRITE;
         end
         WRITE: begin
            busy_o     = 1'b1;
            bus.cyc_o  = 1'b1;
            bus.we_o   = 1'b1;
            bus.stb_o  = (outstanding < MAX_OUT) && (req_count <= LAST_REQ);
            bus.addr_o = req_addr;
            bus.data_o = gen_value;
            if (accept && last_req) state_next = WDRAIN;
         end
         WDRAIN: begin
            busy_o    = 1'b1;
            bus.cyc_o = 1'b1;
            if (outstanding == 4'd0) state_next = READ;
         end
         READ: begin
            busy_o     = 1'b1;
            bus.cyc_o  = 1'b1;
            bus.stb_o  = (outstanding < MAX_OUT) && (req_count <= LAST_REQ);
            bus.addr_o = req_addr;
            if (accept && last_req) state_next = RDRAIN;
         end
         RDRAIN: begin
            busy_o    = 1'b1;
            bus.cyc_o = 1'b1;
            if (outstanding == 4'd0) state_next = DONE;
         end
         DONE: begin
            done_o = 1'b1;
            if (start_i) state_next = WRITE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign pass_o = done_o && (err_count_o == 16'd0);

   // Request index restarts for each pass; outstanding nets accept against ack.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         req_count   <= 21'd0;
         outstanding <= 4'd0;
      end else begin
         if (start_run || read_start) req_count <= 21'd0;
         else if (accept)             req_count <= req_count + 21'd1;
         case ({accept, ack_valid})
            2'b10:   outstanding <= outstanding + 4'd1;
            2'b01:   outstanding <= outstanding - 4'd1;
            default: outstanding <= outstanding;
         endcase
      end
   end

   sdram_bist_lfsr #(.SEED(SEED)) u_gen (
      .clk     (clk_i),
      .rst     (rst_i),
      .load    (start_run),
      .advance (accept && state == WRITE),
      .value   (gen_value)
   );

   sdram_bist_lfsr #(.SEED(SEED)) u_chk (
      .clk     (clk_i),
      .rst     (rst_i),
      .load    (read_start),
      .advance (read_ack),
      .value   (chk_value)
   );

   // Acks return in request order, so exp_addr names the word being checked.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         exp_addr    <= 32'd0;
         err_count_o <= 16'd0;
         err_addr_o  <= 32'd0;
      end else if (start_run) begin
         exp_addr    <= 32'd0;
         err_count_o <= 16'd0;
         err_addr_o  <= 32'd0;
      end else begin
         if (read_start)    exp_addr <= BASE_ADDR;
         else if (read_ack) exp_addr <= exp_addr + 32'd4;
         if (mismatch) begin
            if (err_count_o == 16'd0)     err_addr_o  <= exp_addr;
            if (err_count_o != 16'hFFFF)  err_count_o <= err_count_o + 16'd1;
         end
      end
   end

`ifdef SDRAM_BIST_PERF_EN
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)                                 cycles_o <= 32'd0;
      else if (start_run)                        cycles_o <= 32'd0;
      else if (busy_o && cycles_o != 32'hFFFF_FFFF) cycles_o <= cycles_o + 32'd1;
   end
`else
   assign cycles_o = 32'd0;
`endif

endmodule

// File: tb/tb_sdram_bist.sv
// Self-checking bench: Wishbone slave memory model with stalls, latency and read corruption.
module tb_sdram_bist;

   localparam logic [31:0] BASE = 32'h8000_0100;
   localparam int          NW   = 16;
   localparam int          MAXO = 4;
   localparam logic [31:0] SEED = 32'hCAFE_0001;

   typedef struct {
      int   due;
      logic we;
      int   idx;
   } req_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        busy, done, pass;
   logic [15:0] errc;
   logic [31:0] erra, cycles;

   int tests = 0;
   int failures = 0;

   int          stall_mode = 0;
   int          ack_lat = 1;
   logic [NW-1:0] corrupt = '0;
   logic        force_ack = 1'b0;
   int          slv_cycle = 0;
   req_t        pend[$];
   logic [31:0] mem[NW];
   logic [31:0] wr_log[$];
   logic [31:0] rd_log[$];
   logic [31:0] exp_wdata[NW];
   int          max_pend = 0;
   int          hold_viol = 0;
   int          addr_bad = 0;
   logic        prev_stalled = 1'b0;
   logic [31:0] held_addr, held_data;
   logic        held_we;

   sdram_bist_if bus ();

   sdram_bist #(
      .BASE_ADDR       (BASE),
      .WORDS           (NW),
      .MAX_OUTSTANDING (MAXO),
      .SEED            (SEED)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .start_i     (start),
      .bus         (bus),
      .busy_o      (busy),
      .done_o      (done),
      .pass_o      (pass),
      .err_count_o (errc),
      .err_addr_o  (erra),
      .cycles_o    (cycles)
   );

   always #5 clk = ~clk;

   initial begin
      #3_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [31:0] ref_next(input logic [31:0] d);
      return {d[30:0], d[31] ^ d[21] ^ d[1] ^ d[0]};
   endfunction

   // Slave: decides ack, stall and acceptance for the current cycle at the falling edge.
   always @(negedge clk) begin
      req_t r;
      int   idx;
      logic stall_now;
      slv_cycle++;
      if (rst || !bus.cyc_o) begin
         pend.delete();
         bus.stall_i  = 1'b0;
         bus.data_i   = 32'd0;
         bus.ack_i    = force_ack;
         prev_stalled = 1'b0;
      end else begin
         bus.ack_i  = 1'b0;
         bus.data_i = 32'd0;
         if (pend.size() > 0 && pend[0].due <= slv_cycle) begin
            r = pend.pop_front();
            bus.ack_i = 1'b1;
            if (!r.we) bus.data_i = mem[r.idx] ^ {31'd0, corrupt[r.idx]};
         end
         if (prev_stalled && (!bus.stb_o || bus.addr_o !== held_addr ||
                              bus.data_o !== held_data || bus.we_o !== held_we))
            hold_viol++;
         case (stall_mode)
            0:       stall_now = 1'b0;
            1:       stall_now = slv_cycle[0];
            default: stall_now = ($urandom_range(0, 2) == 0);
         endcase
         bus.stall_i  = stall_now;
         prev_stalled = bus.stb_o && stall_now;
         held_addr    = bus.addr_o;
         held_data    = bus.data_o;
         held_we      = bus.we_o;
         if (bus.stb_o && !stall_now) begin
            idx = int'((bus.addr_o - BASE) >> 2);
            if (idx < 0 || idx >= NW) begin
               addr_bad++;
               idx = 0;
            end
            r.due = slv_cycle + ack_lat;
            r.we  = bus.we_o;
            r.idx = idx;
            pend.push_back(r);
            if (bus.we_o) begin
               mem[idx] = bus.data_o;
               wr_log.push_back(bus.addr_o);
            end else begin
               rd_log.push_back(bus.addr_o);
            end
            if (pend.size() > max_pend) max_pend = pend.size();
         end
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic clearSlave(input int smode, input int lat, input logic [NW-1:0] cmask);
      stall_mode = smode;
      ack_lat    = lat;
      corrupt    = cmask;
      wr_log.delete();
      rd_log.delete();
      max_pend   = 0;
      hold_viol  = 0;
      addr_bad   = 0;
      for (int i = 0; i < NW; i++) mem[i] = 32'd0;
   endtask

   // One full run; expectations come from the corruption mask and the pattern table.
   task automatic applyStimulus(input string tag, input int smode, input int lat,
                                input logic [NW-1:0] cmask, input int restart_at);
      int busy_cnt;
      int n;
      int nerr;
      int first;
      int bad;
      clearSlave(smode, lat, cmask);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checkOutput({tag, " clear done"}, {31'd0, done}, 32'd0);
      checkOutput({tag, " clear errc"}, {16'd0, errc}, 32'd0);
      checkOutput({tag, " clear erra"}, erra, 32'd0);
      checkOutput({tag, " clear cycles"}, cycles, 32'd0);
      checkOutput({tag, " busy"}, {31'd0, busy}, 32'd1);
      busy_cnt = 0;
      n = 0;
      while (!done && n < 3000) begin
         if (busy) busy_cnt++;
         start = (n == restart_at);
         @(negedge clk);
         n++;
      end
      start = 1'b0;
      nerr  = $countones(cmask);
      first = 0;
      for (int i = NW - 1; i >= 0; i--) if (cmask[i]) first = i;
      checkOutput({tag, " done"}, {31'd0, done}, 32'd1);
      checkOutput({tag, " busy end"}, {31'd0, busy}, 32'd0);
      checkOutput({tag, " pass"}, {31'd0, pass}, (nerr == 0) ? 32'd1 : 32'd0);
      checkOutput({tag, " errc"}, {16'd0, errc}, 32'(nerr));
      checkOutput({tag, " erra"}, erra, (nerr == 0) ? 32'd0 : BASE + 32'(4 * first));
`ifdef SDRAM_BIST_PERF_EN
      checkOutput({tag, " cycles"}, cycles, 32'(busy_cnt));
`else
      checkOutput({tag, " cycles"}, cycles, 32'd0);
`endif
      checkOutput({tag, " writes"}, 32'(wr_log.size()), 32'(NW));
      checkOutput({tag, " reads"}, 32'(rd_log.size()), 32'(NW));
      bad = 0;
      for (int i = 0; i < NW; i++) begin
         if (i >= wr_log.size() || wr_log[i] !== BASE + 32'(4 * i)) bad++;
         if (i >= rd_log.size() || rd_log[i] !== BASE + 32'(4 * i)) bad++;
         if (mem[i] !== exp_wdata[i]) bad++;
      end
      checkOutput({tag, " addr/data order errors"}, 32'(bad), 32'd0);
      checkOutput({tag, " outstanding bound"}, {31'd0, (max_pend <= MAXO)}, 32'd1);
      checkOutput({tag, " stall hold"}, 32'(hold_viol), 32'd0);
      checkOutput({tag, " addr range"}, 32'(addr_bad), 32'd0);
   endtask

   initial begin
      int n;
      bus.ack_i   = 1'b0;
      bus.stall_i = 1'b0;
      bus.data_i  = 32'd0;
      exp_wdata[0] = SEED;
      for (int i = 1; i < NW; i++) exp_wdata[i] = ref_next(exp_wdata[i-1]);

      repeat (3) @(negedge clk);
      checkOutput("reset cyc", {31'd0, bus.cyc_o}, 32'd0);
      checkOutput("reset stb", {31'd0, bus.stb_o}, 32'd0);
      checkOutput("reset busy", {31'd0, busy}, 32'd0);
      checkOutput("reset done", {31'd0, done}, 32'd0);
      checkOutput("reset pass", {31'd0, pass}, 32'd0);
      checkOutput("reset addr", bus.addr_o, 32'd0);
      checkOutput("reset sel", {28'd0, bus.sel_o}, 32'hF);
      rst = 1'b0;
      @(negedge clk);

      applyStimulus("ideal", 0, 1, '0, -1);
      applyStimulus("stall2 lat6", 1, 6, '0, -1);
      applyStimulus("corrupt", 0, 1, 16'h0300, -1);
      applyStimulus("restart in write", 2, 3, '0, 3);

      force_ack = 1'b1;
      repeat (2) @(negedge clk);
      force_ack = 1'b0;
      applyStimulus("after stray ack", 0, 2, '0, -1);

      // Reset while three reads are in flight.
      clearSlave(0, 6, '0);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (!(rd_log.size() == 3 && pend.size() == 3) && n < 500) begin
         @(posedge clk);
         #1;
         n++;
      end
      checkOutput("reach 3 outstanding", {31'd0, (n < 500)}, 32'd1);
      rst = 1'b1;
      #1;
      checkOutput("midrun reset cyc", {31'd0, bus.cyc_o}, 32'd0);
      checkOutput("midrun reset stb", {31'd0, bus.stb_o}, 32'd0);
      checkOutput("midrun reset busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      applyStimulus("after reset", 1, 4, '0, -1);

      for (int k = 0; k < 3; k++) begin
         applyStimulus($sformatf("random%0d", k), 2, $urandom_range(1, 7),
                       NW'($urandom) & NW'($urandom), -1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule

// File: doc/sdram_bist.md
SDRAM_BIST -- requirements
Module: sdram_bist

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of the first word tested (word aligned).
REQ-002 SHALL have parameter WORDS, default 1024, number of 32-bit words tested (range 1..2^20).
REQ-003 SHALL have parameter MAX_OUTSTANDING, default 4, maximum accepted requests not yet acknowledged (range 1..15).
REQ-004 SHALL have parameter SEED, default 32'h1234_5678, LFSR start value (nonzero).
REQ-005 clk_i  in  1  single clock; all logic on its rising edge.
REQ-006 rst_i  in  1  reset, asynchronous, active-high.
REQ-007 start_i  in  1  one-cycle pulse that starts a test run.
REQ-008 addr_o  out  32  Wishbone byte address.
REQ-009 data_o  out  32  Wishbone write data.
REQ-010 data_i  in  32  Wishbone read data.
REQ-011 sel_o  out  4  byte select, always 4'hF.
REQ-012 stb_o / cyc_o / we_o  out  1 each  Wishbone pipelined strobe, cycle, write enable.
REQ-013 stall_i / ack_i  in  1 each  Wishbone pipelined stall, acknowledge.
REQ-014 busy_o  out  1  run in progress.
REQ-015 done_o  out  1  run complete; held until next start.
REQ-016 pass_o  out  1  valid with done_o; 1 = zero mismatches.
REQ-017 err_count_o  out  16  mismatch count, saturating at 16'hFFFF.
REQ-018 err_addr_o  out  32  address of the first mismatch.
REQ-019 cycles_o  out  32  clock cycles from start to done.

Function
REQ-020 SHALL implement states IDLE, WRITE, WDRAIN, READ, RDRAIN, DONE.
REQ-021 IDLE/DONE -> WRITE on start_i; start_i SHALL be ignored in all other states.
REQ-022 A request SHALL be accepted when stb_o && !stall_i; addr_o/data_o/we_o SHALL hold stable while stalled.
REQ-023 stb_o SHALL assert only when outstanding < MAX_OUTSTANDING and requests remain in the current pass.
REQ-024 Outstanding counter SHALL +1 on acceptance, -1 on ack_i, unchanged when both occur in the same cycle.
REQ-025 Addresses SHALL run BASE_ADDR, +4, ... BASE_ADDR+4*(WORDS-1), wrapping modulo 2^32.
REQ-026 Write data SHALL be a 32-bit LFSR loaded with SEED at pass start, advanced per accepted write; next = {d[30:0], d[31]^d[21]^d[1]^d[0]}.
REQ-027 WRITE -> WDRAIN after the WORDS-th acceptance; WDRAIN -> READ when outstanding reaches 0.
REQ-028 READ SHALL re-issue the same address sequence with we_o=0; READ -> RDRAIN after the WORDS-th acceptance; RDRAIN -> DONE when outstanding reaches 0.
REQ-029 A separate expected-data LFSR, reseeded with SEED at READ entry, SHALL advance on each read ack_i and compare against data_i in that cycle.
REQ-030 Expected-address counter SHALL track ack order; first mismatch SHALL load err_addr_o; later mismatches SHALL only count.
REQ-031 cyc_o SHALL be high from WRITE entry through RDRAIN exit, low in IDLE/DONE, including across WDRAIN->READ.
REQ-032 ack_i received with outstanding 0 SHALL be ignored and SHALL NOT underflow the counter.
REQ-033 On start from DONE, done_o, pass_o, err_count_o, err_addr_o, cycles_o SHALL clear the cycle after start_i.
REQ-034 busy_o SHALL be high in WRITE..RDRAIN; done_o high only in DONE; pass_o = (err_count_o==0) in DONE, else 0.

Reset
REQ-035 rst_i SHALL asynchronously force IDLE and all outputs to 0 except sel_o=4'hF, including mid-run (cyc_o/stb_o drop immediately; outstanding cleared).

Configuration
REQ-036 With SDRAM_BIST_PERF_EN defined, cycles_o SHALL increment every cycle while busy_o, saturating at 32'hFFFF_FFFF; without it cycles_o SHALL be tied to 0 and the counter not instantiated.

Structure
REQ-037 State enum, LFSR taps and the next-LFSR function SHALL live in package sdram_bist_pkg.
REQ-038 LFSR SHALL be one sub-module sdram_bist_lfsr (load, advance, value), instantiated twice (generate, check).

Verification
REQ-039 WORDS=16, zero-wait ideal slave memory -> 16 writes then 16 reads, done_o, pass_o=1, err_count_o=0.
REQ-040 Slave stalls every 2nd cycle, ack latency 6, MAX_OUTSTANDING=4 -> outstanding never exceeds 4, pass_o=1, no address skipped.
REQ-041 Slave corrupts bit 0 of reads at BASE_ADDR+0x20 and +0x24 -> err_count_o=2, err_addr_o=BASE_ADDR+0x20, pass_o=0.
REQ-042 rst_i asserted during READ with 3 outstanding -> same cycle cyc_o=stb_o=0, busy_o=0; subsequent start_i gives clean pass.
REQ-043 start_i pulsed during WRITE -> ignored, address sequence unchanged; start_i in DONE clears results and reruns.
REQ-044 SDRAM_BIST_PERF_EN defined, WORDS=1, ack 1 cycle after each accept -> cycles_o equals measured busy_o high count; undefined -> cycles_o=0.
